// File: rtl/w_port_arbiter.sv
// Round-robin, packet-granular arbiter sharing one async-FIFO write port
// among NUM_REQ write-domain requesters; every beat is gated on the full flag.
module w_port_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  CNT_WIDTH  = 16,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_w_i,
  input  logic                          rst_w_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          w_full_i,
  output logic                          w_en_o,
  output logic [DATA_WIDTH-1:0]         w_data_o,
  output logic                          grant_vld_o,
  output logic [IDX_WIDTH-1:0]          grant_idx_o,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_next;
  logic [IDX_WIDTH-1:0]   last_idx, last_idx_next;
  logic [IDX_WIDTH-1:0]   grant_idx_next;
  logic                   grant_vld_next;
  logic [CNT_WIDTH-1:0]   pkt_cnt_next;
  logic [IDX_WIDTH-1:0]   arb_idx, cand;
  logic                   arb_hit;
  logic                   xfer;

  function automatic int wrap_add(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
  endfunction

  // Search downward in offset so the smallest offset from last_idx+1 wins last.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_WIDTH'(wrap_add(int'(last_idx), i));
      if (req_valid_i[cand]) begin
        arb_idx = cand;
        arb_hit = 1'b1;
      end
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path through the case leaves a latch.
  always_comb begin
    state_next     = state;
    grant_idx_next = grant_idx_o;
    grant_vld_next = grant_vld_o;
    last_idx_next  = last_idx;
    pkt_cnt_next   = pkt_cnt_o;
    xfer           = 1'b0;
    w_en_o         = 1'b0;
    req_ready_o    = '0;
    w_data_o       = req_data_i[grant_idx_o*DATA_WIDTH +: DATA_WIDTH];

    case (state)
      IDLE: begin
        if (arb_hit) begin
          grant_idx_next = arb_idx;
          grant_vld_next = 1'b1;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        xfer        = req_valid_i[grant_idx_o] & ~w_full_i;
        w_en_o      = xfer;
        req_ready_o = w_full_i ? '0 : (NUM_REQ'(1) << grant_idx_o);
        if (xfer && req_last_i[grant_idx_o]) begin
          last_idx_next  = grant_idx_o;
          pkt_cnt_next   = pkt_cnt_o + CNT_WIDTH'(1);
          grant_vld_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset that overrides every other input.
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i) begin
      state       <= IDLE;
      grant_vld_o <= 1'b0;
      grant_idx_o <= '0;
      last_idx    <= IDX_WIDTH'(NUM_REQ - 1);
      pkt_cnt_o   <= '0;
    end else begin
      state       <= state_next;
      grant_vld_o <= grant_vld_next;
      grant_idx_o <= grant_idx_next;
      last_idx    <= last_idx_next;
      pkt_cnt_o   <= pkt_cnt_next;
    end
  end

endmodule

// File: tb/tb_w_port_arbiter.sv
// Scoreboard bench for w_port_arbiter: stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares every observed write.
module tb_w_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk_w_i = 1'b0;
  logic              rst_w_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_last_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic              w_full_i;
  logic              w_en_o;
  logic [DW-1:0]     w_data_o;
  logic              grant_vld_o;
  logic [IW-1:0]     grant_idx_o;
  logic [CW-1:0]     pkt_cnt_o;

  always #5 clk_w_i = ~clk_w_i;

  w_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_w_i     (clk_w_i),
    .rst_w_i     (rst_w_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .w_full_i    (w_full_i),
    .w_en_o      (w_en_o),
    .w_data_o    (w_data_o),
    .grant_vld_o (grant_vld_o),
    .grant_idx_o (grant_idx_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  typedef struct { logic [DW-1:0] data; logic last; int gap; } beat_t;
  typedef struct { int k; logic [DW-1:0] data; } exp_t;

  beat_t        beats [NR][$];
  exp_t         exp_q [$];
  int           gap_cnt [NR];
  logic [NR-1:0] acc;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           wr_count = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_w_i);
    #2;
  endtask

  task automatic push_beat(input int k, input logic [DW-1:0] d, input logic last, input int gap);
    beat_t b;
    exp_t  e;
    b.data = d; b.last = last; b.gap = gap;
    e.k = k; e.data = d;
    beats[k].push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_w_i = 1'b1;
    tick();
    tick();
    rst_w_i = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && grant_vld_o == 1'b0 && req_valid_i == '0) done = 1'b1;
      else tick();
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: %0d writes still pending after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic wait_writes(input int target, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (wr_count >= target) done = 1'b1;
      else tick();
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL write_timeout: got %0d writes expected %0d", wr_count, target);
    end
  endtask

  // Requester models: hold valid/data/last until accepted, optional gap before a beat.
  initial begin
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    for (int k = 0; k < NR; k++) gap_cnt[k] = 0;
    forever begin
      @(negedge clk_w_i);
      acc = req_valid_i & req_ready_o;
      @(posedge clk_w_i);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (rst_w_i) begin
          beats[k].delete();
          gap_cnt[k] = 0;
        end else if (acc[k] && beats[k].size() > 0) begin
          void'(beats[k].pop_front());
          if (beats[k].size() > 0) gap_cnt[k] = beats[k][0].gap;
        end
        if (beats[k].size() > 0 && gap_cnt[k] == 0) begin
          req_valid_i[k]          = 1'b1;
          req_last_i[k]           = beats[k][0].last;
          req_data_i[k*DW +: DW]  = beats[k][0].data;
        end else begin
          req_valid_i[k] = 1'b0;
          req_last_i[k]  = 1'b0;
          if (gap_cnt[k] > 0) gap_cnt[k]--;
        end
      end
    end
  end

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk_w_i) begin
    if (!rst_w_i && w_en_o) begin
      exp_t e;
      wr_count++;
      if (w_full_i) check("write_while_full", 32'(w_en_o), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%0h expected no write", w_data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(w_data_o), 32'(e.data));
        check("wr_grant_idx", 32'(grant_idx_o), 32'(e.k));
        check("wr_ready", 32'(req_ready_o), 32'(1) << e.k);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_w_i  = 1'b1;
    w_full_i = 1'b0;
    do_reset();
    check("rst_grant_vld", 32'(grant_vld_o), 32'd0);
    check("rst_grant_idx", 32'(grant_idx_o), 32'd0);
    check("rst_pkt_cnt",   32'(pkt_cnt_o),   32'd0);
    check("rst_w_en",      32'(w_en_o),      32'd0);
    check("rst_ready",     32'(req_ready_o), 32'd0);

    // Single requester, 3-beat packet.
    push_beat(0, 8'hA1, 1'b0, 0);
    push_beat(0, 8'hA2, 1'b0, 0);
    push_beat(0, 8'hA3, 1'b1, 0);
    tick();
    check("arb_cycle_no_grant", 32'(grant_vld_o), 32'd0);
    tick();
    check("single_grant_vld", 32'(grant_vld_o), 32'd1);
    check("single_grant_idx", 32'(grant_idx_o), 32'd0);
    check("single_w_en_b1", 32'(w_en_o), 32'd1);
    tick();
    check("single_w_en_b2", 32'(w_en_o), 32'd1);
    tick();
    check("single_w_en_b3", 32'(w_en_o), 32'd1);
    tick();
    check("single_w_en_done", 32'(w_en_o), 32'd0);
    check("single_grant_released", 32'(grant_vld_o), 32'd0);
    check("single_pkt_cnt", 32'(pkt_cnt_o), 32'd1);

    // Round robin from reset: expected order 0,1,2,3,0.
    do_reset();
    push_beat(0, 8'h10, 1'b1, 0);
    push_beat(1, 8'h11, 1'b1, 0);
    push_beat(2, 8'h12, 1'b1, 0);
    push_beat(3, 8'h13, 1'b1, 0);
    push_beat(0, 8'h10, 1'b1, 0);
    exp_cnt = 4'd5;
    wait_idle(100);
    check("rr_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

    // Backpressure: full for 4 cycles after beat 2 of a 4-beat packet from requester 1.
    base = wr_count;
    push_beat(1, 8'hB1, 1'b0, 0);
    push_beat(1, 8'hB2, 1'b0, 0);
    push_beat(1, 8'hB3, 1'b0, 0);
    push_beat(1, 8'hB4, 1'b1, 0);
    wait_writes(base + 2, 50);
    w_full_i = 1'b1;
    repeat (4) begin
      #1;
      check("full_w_en", 32'(w_en_o), 32'd0);
      check("full_ready", 32'(req_ready_o), 32'd0);
      check("full_grant_idx", 32'(grant_idx_o), 32'd1);
      check("full_grant_vld", 32'(grant_vld_o), 32'd1);
      tick();
    end
    w_full_i = 1'b0;
    wait_idle(100);
    exp_cnt = exp_cnt + 4'd1;
    check("bp_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

    // Valid gap: requester 2 idles 3 cycles mid-packet while requester 1 waits.
    base = wr_count;
    push_beat(2, 8'hC1, 1'b0, 0);
    push_beat(2, 8'hC2, 1'b0, 3);
    push_beat(2, 8'hC3, 1'b1, 0);
    push_beat(1, 8'hD1, 1'b1, 0);
    wait_writes(base + 1, 50);
    repeat (3) begin
      check("gap_w_en", 32'(w_en_o), 32'd0);
      check("gap_grant_idx", 32'(grant_idx_o), 32'd2);
      check("gap_grant_vld", 32'(grant_vld_o), 32'd1);
      tick();
    end
    wait_idle(100);
    exp_cnt = exp_cnt + 4'd2;
    check("gap_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

    // Reset during beat 2 of 4.
    base = wr_count;
    push_beat(0, 8'hE1, 1'b0, 0);
    push_beat(0, 8'hE2, 1'b0, 0);
    push_beat(0, 8'hE3, 1'b0, 0);
    push_beat(0, 8'hE4, 1'b1, 0);
    wait_writes(base + 1, 50);
    rst_w_i = 1'b1;
    tick();
    check("midrst_grant_vld", 32'(grant_vld_o), 32'd0);
    check("midrst_w_en", 32'(w_en_o), 32'd0);
    check("midrst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    check("midrst_ready", 32'(req_ready_o), 32'd0);
    rst_w_i = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    push_beat(1, 8'hF1, 1'b1, 0);
    push_beat(3, 8'hF3, 1'b1, 0);
    wait_idle(100);
    exp_cnt = 4'd2;
    check("midrst_after_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

    // Counter wrap with a 4-bit counter: 15, 0, 1 after packets 15, 16, 17.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      push_beat((i - 1) % NR, 8'(8'h40 + i), 1'b1, 0);
      exp_cnt = exp_cnt + 4'd1;
      wait_idle(50);
      if (i >= 15) check("wrap_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
